// File: rtl/traffic_pkg.sv
// Shared light-bus definitions: light codes, lamp one-hot patterns, decoder
// state and fault cause bit positions.
package traffic_pkg;

    localparam logic [2:0] RED           = 3'b000;
    localparam logic [2:0] GREEN         = 3'b001;
    localparam logic [2:0] YELLOW        = 3'b010;
    localparam logic [2:0] LEFT          = 3'b011;
    localparam logic [2:0] GREEN_TWINKLE = 3'b100;

    // car lamps {left, green, yellow, red}; walker lamps {green, red}
    localparam logic [3:0] CAR_RED    = 4'b0001;
    localparam logic [3:0] CAR_YELLOW = 4'b0010;
    localparam logic [3:0] CAR_GREEN  = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b1000;
    localparam logic [1:0] WALK_RED   = 2'b01;
    localparam logic [1:0] WALK_GREEN = 2'b10;
    localparam logic [1:0] WALK_OFF   = 2'b00;

    typedef enum logic [1:0] {INIT, RUN, FAULT} state_e;

    localparam int FC_ILLEGAL    = 0;
    localparam int FC_H_CONFLICT = 1;
    localparam int FC_V_CONFLICT = 2;
    localparam int FC_CAR_CROSS  = 3;

    function automatic logic car_legal(input logic [2:0] c);
        return c <= GREEN_TWINKLE;
    endfunction

    function automatic logic walker_legal(input logic [2:0] w);
        return (w == RED) || (w == GREEN) || (w == GREEN_TWINKLE);
    endfunction

    function automatic logic [3:0] car_decode(input logic [2:0] c);
        case (c)
            GREEN:   return CAR_GREEN;
            YELLOW:  return CAR_YELLOW;
            LEFT:    return CAR_LEFT;
            default: return CAR_RED;
        endcase
    endfunction

    function automatic logic [1:0] walker_decode(input logic [2:0] w, input logic phase);
        case (w)
            GREEN:         return WALK_GREEN;
            GREEN_TWINKLE: return {phase, 1'b0};
            default:       return WALK_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_lamp_decoder_if.sv
// Encoded light bus from the controller plus the decoded lamp drives and fault status.
interface traffic_lamp_decoder_if;
    logic [2:0] h_car_traffic;
    logic [2:0] h_walker_traffic;
    logic [2:0] v_car_traffic;
    logic [2:0] v_walker_traffic;
    logic [3:0] h_car_lamp;
    logic [3:0] v_car_lamp;
    logic [1:0] h_walker_lamp;
    logic [1:0] v_walker_lamp;
    logic       fault;
    logic [3:0] fault_code;

    modport master (
        output h_car_traffic, h_walker_traffic, v_car_traffic, v_walker_traffic,
        input  h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault, fault_code
    );
    modport slave (
        input  h_car_traffic, h_walker_traffic, v_car_traffic, v_walker_traffic,
        output h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault, fault_code
    );
endinterface

// File: rtl/traffic_blink_gen.sv
// Free-running blink phase: toggles every BLINK_HALF cycles, starts high out of reset.
module traffic_blink_gen #(
    parameter int BLINK_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic phase
);
    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == CW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/traffic_lamp_decoder.sv
// Registers the light bus, decodes lamps and forces flashing-yellow fail-safe on violations.
// Define TRAFFIC_FAULT_LATCH_EN to make FAULT terminal (exit only through rst_n).
module traffic_lamp_decoder
    import traffic_pkg::*;
#(
    parameter int BLINK_HALF = 4,
    parameter int FAULT_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    traffic_lamp_decoder_if.slave  bus
);
    logic [2:0] s1_hc, s1_hw, s1_vc, s1_vw;
    logic       phase;
    state_e     state, state_n;
    logic       init_cnt, init_cnt_n;
    logic [3:0] viol;
    logic [3:0] hc_q, vc_q, hc_n, vc_n, fc_q, fc_n;
    logic [1:0] hw_q, vw_q, hw_n, vw_n;
    logic       fault_q;
`ifndef TRAFFIC_FAULT_LATCH_EN
    localparam int CCW = $clog2(FAULT_HOLD + 1);
    logic [CCW-1:0] clean_cnt, clean_cnt_n;
`endif

    traffic_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hc <= RED;
            s1_hw <= RED;
            s1_vc <= RED;
            s1_vw <= RED;
        end else begin
            s1_hc <= bus.h_car_traffic;
            s1_hw <= bus.h_walker_traffic;
            s1_vc <= bus.v_car_traffic;
            s1_vw <= bus.v_walker_traffic;
        end
    end

    always_comb begin
        viol = '0;
        viol[FC_ILLEGAL]    = !car_legal(s1_hc) || !car_legal(s1_vc) ||
                              !walker_legal(s1_hw) || !walker_legal(s1_vw);
        viol[FC_H_CONFLICT] = (s1_hc != RED) && (s1_hw != RED);
        viol[FC_V_CONFLICT] = (s1_vc != RED) && (s1_vw != RED);
        viol[FC_CAR_CROSS]  = (s1_hc != RED) && (s1_vc != RED);
    end

    always_comb begin
        state_n    = state;
        init_cnt_n = 1'b0;
`ifndef TRAFFIC_FAULT_LATCH_EN
        clean_cnt_n = '0;
`endif
        case (state)
            INIT: begin
                if (|viol)         state_n = FAULT;
                else if (init_cnt) state_n = RUN;
                else               init_cnt_n = 1'b1;
            end
            RUN: if (|viol) state_n = FAULT;
            FAULT: begin
`ifndef TRAFFIC_FAULT_LATCH_EN
                // this clean cycle completes the hold window
                if (|viol)                                clean_cnt_n = '0;
                else if (clean_cnt == CCW'(FAULT_HOLD - 1)) state_n = INIT;
                else                                      clean_cnt_n = clean_cnt + 1'b1;
`endif
            end
            default: state_n = INIT;
        endcase
    end

    // Lamps follow the next state so a violation never shows up on the pins.
    always_comb begin
        hc_n = CAR_RED;
        vc_n = CAR_RED;
        hw_n = WALK_RED;
        vw_n = WALK_RED;
        fc_n = '0;
        case (state_n)
            RUN: begin
                hc_n = car_decode(s1_hc);
                vc_n = car_decode(s1_vc);
                hw_n = walker_decode(s1_hw, phase);
                vw_n = walker_decode(s1_vw, phase);
            end
            FAULT: begin
                hc_n = {2'b00, phase, 1'b0};
                vc_n = {2'b00, phase, 1'b0};
                hw_n = WALK_OFF;
                vw_n = WALK_OFF;
                fc_n = ((state == FAULT) ? fc_q : 4'b0) | viol;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= 1'b0;
            hc_q     <= CAR_RED;
            vc_q     <= CAR_RED;
            hw_q     <= WALK_RED;
            vw_q     <= WALK_RED;
            fc_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
            hc_q     <= hc_n;
            vc_q     <= vc_n;
            hw_q     <= hw_n;
            vw_q     <= vw_n;
            fc_q     <= fc_n;
            fault_q  <= (state_n == FAULT);
        end
    end

`ifndef TRAFFIC_FAULT_LATCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clean_cnt <= '0;
        else        clean_cnt <= clean_cnt_n;
    end
`endif

    assign bus.h_car_lamp    = hc_q;
    assign bus.v_car_lamp    = vc_q;
    assign bus.h_walker_lamp = hw_q;
    assign bus.v_walker_lamp = vw_q;
    assign bus.fault         = fault_q;
    assign bus.fault_code    = fc_q;
endmodule

// File: tb/tb_traffic_lamp_decoder.sv
// Randomized light-bus stimulus checked every cycle against a rule-level model.
module tb_traffic_lamp_decoder;
    localparam int BH   = 4;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    traffic_lamp_decoder_if bus ();

    traffic_lamp_decoder #(.BLINK_HALF(BH), .FAULT_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] causes(input logic [2:0] hc, hw, vc, vw);
        logic [3:0] c;
        c[0] = (hc > 3'd4) || (vc > 3'd4) ||
               !(hw == 3'd0 || hw == 3'd1 || hw == 3'd4) ||
               !(vw == 3'd0 || vw == 3'd1 || vw == 3'd4);
        c[1] = (hc != 0) && (hw != 0);
        c[2] = (vc != 0) && (vw != 0);
        c[3] = (hc != 0) && (vc != 0);
        return c;
    endfunction

    function automatic logic [3:0] car_lamp(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b0100;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b1000;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [1:0] walk_lamp(input logic [2:0] w, input logic ph);
        case (w)
            3'd1:    return 2'b10;
            3'd4:    return {ph, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    // Model: mode 0 = all red start-up, 1 = normal, 2 = fail-safe
    int         n, mode, init_left, clean;
    logic [3:0] m_causes;
    logic [2:0] m_hc, m_hw, m_vc, m_vw;
    logic [3:0] e_hc, e_vc, e_fc;
    logic [1:0] e_hw, e_vw;
    logic       e_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; mode = 0; init_left = 2; clean = 0; m_causes = 0;
            m_hc = 0; m_hw = 0; m_vc = 0; m_vw = 0;
            e_hc = 4'b0001; e_vc = 4'b0001; e_hw = 2'b01; e_vw = 2'b01;
            e_fc = 0; e_fault = 0;
        end else begin
            logic [3:0] v;
            logic ph;
            n++;
            ph = (((n - 1) / BH) % 2) == 0;
            v = causes(m_hc, m_hw, m_vc, m_vw);
            if (mode == 2) begin
`ifdef TRAFFIC_FAULT_LATCH_EN
                m_causes |= v;
`else
                if (v != 0) begin
                    clean = 0;
                    m_causes |= v;
                end else begin
                    clean++;
                    if (clean == HOLD) begin
                        mode = 0; init_left = 2; clean = 0; m_causes = 0;
                    end
                end
`endif
            end else if (v != 0) begin
                mode = 2; m_causes = v; clean = 0;
            end else if (mode == 0) begin
                init_left--;
                if (init_left == 0) mode = 1;
            end
            case (mode)
                1: begin
                    e_hc = car_lamp(m_hc); e_vc = car_lamp(m_vc);
                    e_hw = walk_lamp(m_hw, ph); e_vw = walk_lamp(m_vw, ph);
                end
                2: begin
                    e_hc = {2'b00, ph, 1'b0}; e_vc = {2'b00, ph, 1'b0};
                    e_hw = 2'b00; e_vw = 2'b00;
                end
                default: begin
                    e_hc = 4'b0001; e_vc = 4'b0001; e_hw = 2'b01; e_vw = 2'b01;
                end
            endcase
            e_fault = (mode == 2);
            e_fc    = (mode == 2) ? m_causes : 4'b0;
            m_hc = bus.h_car_traffic;    m_hw = bus.h_walker_traffic;
            m_vc = bus.v_car_traffic;    m_vw = bus.v_walker_traffic;
        end
    end

    always @(negedge clk) begin
        chk("h_car_lamp", bus.h_car_lamp, e_hc);
        chk("v_car_lamp", bus.v_car_lamp, e_vc);
        chk("h_walker_lamp", {2'b00, bus.h_walker_lamp}, {2'b00, e_hw});
        chk("v_walker_lamp", {2'b00, bus.v_walker_lamp}, {2'b00, e_vw});
        chk("fault", {3'b000, bus.fault}, {3'b000, e_fault});
        chk("fault_code", bus.fault_code, e_fc);
    end

    task automatic drive(input logic [2:0] hc, hw, vc, vw);
        bus.h_car_traffic = hc; bus.h_walker_traffic = hw;
        bus.v_car_traffic = vc; bus.v_walker_traffic = vw;
    endtask

    task automatic pick(output logic [2:0] hc, hw, vc, vw);
        logic [2:0] wl[3] = '{3'd0, 3'd1, 3'd4};
        logic [2:0] cl[3] = '{3'd1, 3'd2, 3'd3};
        int r = $urandom_range(0, 19);
        hc = 0; hw = 0; vc = 0; vw = 0;
        if (r == 0) begin
            hc = 3'($urandom_range(0, 7)); hw = 3'($urandom_range(0, 7));
            vc = 3'($urandom_range(0, 7)); vw = 3'($urandom_range(0, 7));
        end else if (r < 6) begin
            hw = wl[$urandom_range(0, 2)]; vw = wl[$urandom_range(0, 2)];
        end else if (r < 13) begin
            hc = cl[$urandom_range(0, 2)]; vw = wl[$urandom_range(0, 2)];
        end else begin
            vc = cl[$urandom_range(0, 2)]; hw = wl[$urandom_range(0, 2)];
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst h_car_lamp", bus.h_car_lamp, 4'b0001);
        chk("rst v_walker_lamp", {2'b00, bus.v_walker_lamp}, 4'b0001);
        chk("rst fault", {3'b000, bus.fault}, 4'b0000);
        chk("rst fault_code", bus.fault_code, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] hc, hw, vc, vw;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset h_car_lamp", bus.h_car_lamp, 4'b0001);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("run idle h_car_lamp", bus.h_car_lamp, 4'b0001);
        chk("run idle fault", {3'b000, bus.fault}, 4'b0000);

        drive(3'd1, 3'd0, 3'd0, 3'd1);
        repeat (2) @(negedge clk);
        chk("go h_car_lamp", bus.h_car_lamp, 4'b0100);
        chk("go v_walker_lamp", {2'b00, bus.v_walker_lamp}, 4'b0010);

        drive(3'd1, 3'd0, 3'd2, 3'd0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("cross fault", {3'b000, bus.fault}, 4'b0001);
        chk("cross fault_code", bus.fault_code, 4'b1000);
        chk("cross walkers dark", {2'b00, bus.h_walker_lamp}, 4'b0000);
        repeat (15) @(negedge clk);
        chk("hold fault", {3'b000, bus.fault}, 4'b0001);
        @(negedge clk);
        chk("recover fault", {3'b000, bus.fault}, 4'b0000);
        chk("recover h_car_lamp", bus.h_car_lamp, 4'b0001);

        repeat (3) @(negedge clk);
        drive(3'd1, 3'd0, 3'd1, 3'd0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        repeat (10) @(negedge clk);
        drive(3'd0, 3'd0, 3'd0, 3'd3);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("illegal walker fault_code", bus.fault_code, 4'b1001);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            pick(hc, hw, vc, vw);
            drive(hc, hw, vc, vw);
            repeat ($urandom_range(1, 8)) @(negedge clk);
            if (i == 150) pulse_reset();
        end
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/traffic_lamp_decoder.md
# traffic_lamp_decoder

Receiving end of the intersection controller's encoded light bus. Registers the four 3-bit light codes (`RED=000`, `GREEN=001`, `YELLOW=010`, `LEFT=011`, `GREEN_TWINKLE=100`) and decodes them into one-hot lamp drives. It generates the twinkle blink locally and runs a safety monitor. On any illegal code or conflicting combination, the monitor drops to fail-safe: car yellow flashing, walkers dark. Sits between the controller and the lamp driver pins.

## Interface
- `BLINK_HALF`, 4: cycles per blink half-period, ≥1.
- `FAULT_HOLD`, 16: consecutive clean cycles required in FAULT before recovery, ≥1.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `h_car_traffic` in 3: horizontal car code.
- `h_walker_traffic` in 3: horizontal walker code.
- `v_car_traffic` in 3: vertical car code.
- `v_walker_traffic` in 3: vertical walker code.
- `h_car_lamp` out 4: {left, green, yellow, red}.
- `v_car_lamp` out 4: {left, green, yellow, red}.
- `h_walker_lamp` out 2: {green, red}.
- `v_walker_lamp` out 2: {green, red}.
- `fault` out 1: high while state is FAULT.
- `fault_code` out 4: sticky causes during FAULT. Bit0 illegal code; bit1 h_car/h_walker conflict; bit2 v_car/v_walker conflict; bit3 h_car/v_car conflict.

## Operation
- Stage 1: all four codes are registered every cycle.
- Stage 2: violation check and decode run on the stage-1 registers. Lamps, state, `fault` and `fault_code` are all registered outputs.
- Violations:
  - bit0: car code ≥101, or walker code not in {000, 001, 100}.
  - bit1: h_car≠RED and h_walker≠RED.
  - bit2: v_car≠RED and v_walker≠RED.
  - bit3: h_car≠RED and v_car≠RED.
- States:
  - INIT: all lamps red. Stays 2 cycles, then RUN. Any violation in INIT goes to FAULT.
  - RUN: normal decode. Any violation goes to FAULT.
  - FAULT: car lamps = {0,0,phase,0}, walker lamps = 00. `clean_cnt` counts violation-free cycles and clears on any violation. At `clean_cnt==FAULT_HOLD` the state goes to INIT.
- Decode in RUN:
  - Car RED→0001, GREEN→0100, YELLOW→0010, LEFT→1000.
  - Walker RED→01, GREEN→10, GREEN_TWINKLE→{phase,0}.
- Blink generator:
  - `blink_cnt` counts 0..BLINK_HALF-1 and wraps; `phase` toggles on wrap. It runs freely in all states.
  - `phase` resets to 1; the first toggle falls on the BLINK_HALF-th edge after reset release.
- `fault_code` ORs in the causes of every violating cycle while in FAULT, including the entry cycle. It clears on the transition out of FAULT and reads 0 outside FAULT.
- Illegal lamp combinations never reach the outputs: the violation and the FAULT decode take effect on the same edge.

## Timing
- Reset values: all car lamps 0001, walker lamps 01, `fault`=0, `fault_code`=0, state INIT, `blink_cnt`=0, `phase`=1, `clean_cnt`=0, stage-1 registers 000.
- Latency: a code applied before edge k appears on the lamps after edge k+1 (2 edges).
- A violating input before edge k sets `fault=1` after edge k+1.
- Recovery: after the last violating sample, `fault` deasserts FAULT_HOLD+1 edges later. Two INIT (all-red) cycles then precede RUN.
- Reset asserted mid-operation: immediate return to reset values, independent of the clock.
- A violation on the same cycle as `clean_cnt` reaching FAULT_HOLD takes priority: the block stays in FAULT and `clean_cnt` goes to 0.

## Configuration
- `TRAFFIC_FAULT_LATCH_EN` defined: FAULT is terminal. There is no recovery; only `rst_n` exits FAULT, and `clean_cnt` is omitted.
- Not defined: automatic recovery as described above.

## Structure
- Shared package `traffic_pkg` holds:
  - the light code constants (RED/GREEN/YELLOW/LEFT/GREEN_TWINKLE), shared with the controller;
  - lamp one-hot constants;
  - the state enum (INIT/RUN/FAULT);
  - fault_code bit indices.
- One natural sub-module: `traffic_blink_gen` (parameter BLINK_HALF; outputs `phase`).

## Test plan
- Reset release, codes all RED → lamps 0001/01 for 2 cycles (INIT), then RUN with unchanged lamps, `fault`=0.
- h_car=GREEN, v_walker=GREEN, others RED → after 2 edges h_car_lamp=0100, v_walker_lamp=10, `fault`=0.
- h_walker=GREEN_TWINKLE, BLINK_HALF=4 → h_walker_lamp alternates 10/00 every 4 cycles, starting from 10 with phase=1.
- h_car=GREEN and v_car=YELLOW for 1 cycle → `fault`=1, fault_code=1000, car lamps flash 0010/0000, walkers 00. With legal inputs after that, `fault` drops 17 edges after the bad sample, followed by 2 all-red cycles.
- v_walker=011 during FAULT, at clean_cnt=10 → clean_cnt restarts from 0 and fault_code gains bit0.
- `TRAFFIC_FAULT_LATCH_EN` build, one violation then 100 clean cycles → `fault` stays 1; `rst_n` pulse restores reset values.
